guess_game_ctrl: RTL and testbench

- Central sequencer for the three-level number-guessing game.
- Starts the random generator, the countdown/dot-matrix counter and the beeper, and selects what the seven-segment display and LEDs show.
- Compares the switch guess against the latched random value, using 5, 6 and 7 bits for levels 1, 2 and 3.
- Sits between board inputs (debounced buttons, switches) and the existing get_random / counter / beep_beep / disp_show datapath blocks.

---
 rtl/game_pkg.sv | 52 +++++
 rtl/guess_cmp.sv | 25 ++
 rtl/guess_game_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_guess_game_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings and small helpers for the number-guessing game controller.
package game_pkg;

  typedef enum logic [3:0] {
    S_OFF   = 4'd0,
    S_GREET = 4'd1,
    S_ARM   = 4'd2,
    S_PLAY  = 4'd3,
    S_GUESS = 4'd4,
    S_JUDGE = 4'd5,
    S_HIT   = 4'd6,
    S_MISS  = 4'd7,
    S_WIN   = 4'd8,
    S_FAIL  = 4'd9
  } state_e;

  localparam logic [2:0] DZ_OFF   = 3'd0;
  localparam logic [2:0] DZ_GREET = 3'd1;
  localparam logic [2:0] DZ_COUNT = 3'd2;
  localparam logic [2:0] DZ_TICK  = 3'd3;
  localparam logic [2:0] DZ_CROSS = 3'd4;

  localparam logic [2:0] DISP_BLANK = 3'd0;
  localparam logic [2:0] DISP_LEVEL = 3'd1;
  localparam logic [2:0] DISP_HIT   = 3'd2;
  localparam logic [2:0] DISP_MISS  = 3'd3;
  localparam logic [2:0] DISP_WIN   = 3'd4;
  localparam logic [2:0] DISP_FAIL  = 3'd5;

  localparam logic [1:0] BEEP_HIT  = 2'd0;
  localparam logic [1:0] BEEP_MISS = 2'd1;
  localparam logic [1:0] BEEP_WIN  = 2'd2;
  localparam logic [1:0] BEEP_FAIL = 2'd3;

  // Number of guess bits compared at a given level.
  function automatic logic [2:0] lvl_width(input logic [1:0] lvl);
    return {1'b0, lvl} + 3'd4;
  endfunction

  function automatic logic [2:0] therm3(input logic [1:0] n);
    logic [2:0] t;
    case (n)
      2'd0:    t = 3'b000;
      2'd1:    t = 3'b001;
      2'd2:    t = 3'b011;
      2'd3:    t = 3'b111;
      default: t = 3'b000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/guess_cmp.sv
// Masked compare of the switch guess against the target; the mask width
// follows the level and is also what the guess LEDs display.
module guess_cmp
  import game_pkg::*;
(
  input  logic [6:0] guess,
  input  logic [6:0] target,
  input  logic [1:0] level,
  output logic       match,
  output logic [6:0] mask
);

  // Level 0 means idle, where nothing is compared or shown.
  always_comb begin
    mask = 7'h00;
    if (level != 2'd0) begin
      mask = ~(7'h7F << lvl_width(level));
    end else begin
      mask = 7'h00;
    end
  end

  assign match = ((guess ^ target) & mask) == 7'h00;

endmodule

// File: rtl/guess_game_ctrl.sv
// Central sequencer of the three-level guessing game: drives the random,
// countdown, beep and display blocks and judges the player's guesses.
module guess_game_ctrl
  import game_pkg::*;
#(
  parameter logic [2:0] T_L1      = 3'd3,
  parameter logic [2:0] T_L2      = 3'd2,
  parameter logic [2:0] T_L3      = 3'd1,
  parameter logic [1:0] MAX_TRIES = 2'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start_p,
  input  logic        restart_p,
  input  logic [6:0]  guess,
  input  logic [6:0]  rand_num,
  input  logic        cnt_over,
  input  logic        beep_over,
  output logic        rand_st,
  output logic        cnt_start,
  output logic [2:0]  cnt_secs,
  output logic [2:0]  dz_sel,
  output logic        beep_start,
  output logic [1:0]  beep_mode,
  output logic [2:0]  disp_code,
  output logic [1:0]  level,
  output logic [15:0] led
);

  state_e      state_q, state_d;
  logic [1:0]  level_q, level_d;
  logic [1:0]  tries_q, tries_d;
  logic [6:0]  target_q, target_d;
  logic        rand_pend_q;
  logic        new_lvl_s;
  logic        match_s;
  logic [6:0]  mask_s;

  logic        rand_st_q, rand_st_d;
  logic        cnt_start_q, cnt_start_d;
  logic [2:0]  cnt_secs_q, cnt_secs_d;
  logic [2:0]  dz_sel_q, dz_sel_d;
  logic        beep_start_q, beep_start_d;
  logic [1:0]  beep_mode_q, beep_mode_d;
  logic [2:0]  disp_code_q, disp_code_d;
  logic [15:0] led_q, led_d;

  // Fed with the next level so the LED mask lines up with the registered level;
  // in JUDGE the next level always equals the current one.
  guess_cmp u_cmp (
    .guess  (guess),
    .target (target_q),
    .level  (level_d),
    .match  (match_s),
    .mask   (mask_s)
  );

  // Level bookkeeping, kept apart from the state logic that consumes match_s.
  always_comb begin
    level_d   = level_q;
    new_lvl_s = 1'b0;
    if (!en) begin
      level_d = 2'd0;
    end else if (restart_p && (state_q != S_OFF)) begin
      level_d   = 2'd1;
      new_lvl_s = 1'b1;
    end else if ((state_q == S_HIT) && beep_over && (level_q < 2'd3)) begin
      level_d   = level_q + 2'd1;
      new_lvl_s = 1'b1;
    end else begin
      level_d = level_q;
    end
  end

  // Next state and remaining tries.
  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    if (!en) begin
      state_d = S_OFF;
      tries_d = 2'd0;
    end else if (restart_p && (state_q != S_OFF)) begin
      state_d = S_ARM;
      tries_d = MAX_TRIES;
    end else begin
      case (state_q)
        S_OFF:   state_d = S_GREET;
        S_GREET: state_d = S_GREET;
        S_ARM:   state_d = S_PLAY;
        S_PLAY:  state_d = cnt_over ? S_GUESS : S_PLAY;
        S_GUESS: state_d = start_p ? S_JUDGE : S_GUESS;
        S_JUDGE: begin
          if (match_s) begin
            state_d = S_HIT;
          end else if (tries_q > 2'd1) begin
            state_d = S_MISS;
            tries_d = tries_q - 2'd1;
          end else begin
            state_d = S_FAIL;
            tries_d = 2'd0;
          end
        end
        S_HIT: begin
          if (!beep_over) begin
            state_d = S_HIT;
          end else if (level_q < 2'd3) begin
            state_d = S_ARM;
            tries_d = MAX_TRIES;
          end else begin
            state_d = S_WIN;
          end
        end
        S_MISS:  state_d = beep_over ? S_ARM : S_MISS;
        S_WIN:   state_d = S_WIN;
        S_FAIL:  state_d = S_FAIL;
        default: state_d = S_OFF;
      endcase
    end
  end

  // Output decode from the next state so outputs register alongside it.
  always_comb begin
    rand_st_d    = (state_d == S_ARM) && new_lvl_s;
    cnt_start_d  = (state_d == S_ARM);
    beep_start_d = (state_d != state_q) &&
                   (state_d inside {S_HIT, S_MISS, S_WIN, S_FAIL});
    cnt_secs_d   = 3'd0;
    if (state_d == S_ARM) begin
      case (level_d)
        2'd1:    cnt_secs_d = T_L1;
        2'd2:    cnt_secs_d = T_L2;
        2'd3:    cnt_secs_d = T_L3;
        default: cnt_secs_d = 3'd0;
      endcase
    end else begin
      cnt_secs_d = 3'd0;
    end
    dz_sel_d    = DZ_OFF;
    beep_mode_d = BEEP_HIT;
    disp_code_d = DISP_BLANK;
    case (state_d)
      S_GREET: dz_sel_d = DZ_GREET;
      S_ARM, S_PLAY, S_GUESS, S_JUDGE: begin
        dz_sel_d    = DZ_COUNT;
        disp_code_d = DISP_LEVEL;
      end
      S_HIT: begin
        beep_mode_d = BEEP_HIT;
        dz_sel_d    = DZ_TICK;
        disp_code_d = DISP_HIT;
      end
      S_MISS: begin
        beep_mode_d = BEEP_MISS;
        dz_sel_d    = DZ_CROSS;
        disp_code_d = DISP_MISS;
      end
      S_WIN: begin
        beep_mode_d = BEEP_WIN;
        disp_code_d = DISP_WIN;
      end
      S_FAIL: begin
        beep_mode_d = BEEP_FAIL;
        disp_code_d = DISP_FAIL;
      end
      default: dz_sel_d = DZ_OFF;
    endcase
    led_d = {therm3(level_d), therm3(tries_d), 3'b000, guess & mask_s};
  end

  // A fresh random value becomes valid one cycle after rand_st.
  always_comb begin
    if (rand_pend_q) begin
      target_d = rand_num;
    end else begin
      target_d = target_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_OFF;
      level_q      <= 2'd0;
      tries_q      <= 2'd0;
      target_q     <= 7'h00;
      rand_pend_q  <= 1'b0;
      rand_st_q    <= 1'b0;
      cnt_start_q  <= 1'b0;
      cnt_secs_q   <= 3'd0;
      dz_sel_q     <= 3'd0;
      beep_start_q <= 1'b0;
      beep_mode_q  <= 2'd0;
      disp_code_q  <= 3'd0;
      led_q        <= 16'h0000;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      tries_q      <= tries_d;
      target_q     <= target_d;
      rand_pend_q  <= rand_st_q;
      rand_st_q    <= rand_st_d;
      cnt_start_q  <= cnt_start_d;
      cnt_secs_q   <= cnt_secs_d;
      dz_sel_q     <= dz_sel_d;
      beep_start_q <= beep_start_d;
      beep_mode_q  <= beep_mode_d;
      disp_code_q  <= disp_code_d;
      led_q        <= led_d;
    end
  end

  assign rand_st    = rand_st_q;
  assign cnt_start  = cnt_start_q;
  assign cnt_secs   = cnt_secs_q;
  assign dz_sel     = dz_sel_q;
  assign beep_start = beep_start_q;
  assign beep_mode  = beep_mode_q;
  assign disp_code  = disp_code_q;
  assign level      = level_q;
  assign led        = led_q;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed self-checking bench for guess_game_ctrl.
module tb_guess_game_ctrl;

  logic        clk, rst, en, start_p, restart_p, cnt_over, beep_over;
  logic [6:0]  guess, rand_num;
  logic        rand_st, cnt_start, beep_start;
  logic [2:0]  cnt_secs, dz_sel, disp_code;
  logic [1:0]  beep_mode, level;
  logic [15:0] led;

  int checks   = 0;
  int failures = 0;

  guess_game_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .start_p    (start_p),
    .restart_p  (restart_p),
    .guess      (guess),
    .rand_num   (rand_num),
    .cnt_over   (cnt_over),
    .beep_over  (beep_over),
    .rand_st    (rand_st),
    .cnt_start  (cnt_start),
    .cnt_secs   (cnt_secs),
    .dz_sel     (dz_sel),
    .beep_start (beep_start),
    .beep_mode  (beep_mode),
    .disp_code  (disp_code),
    .level      (level),
    .led        (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_restart();
    restart_p = 1'b1;
    tick(1);
    restart_p = 1'b0;
  endtask

  task automatic pulse_beep_over();
    beep_over = 1'b1;
    tick(1);
    beep_over = 1'b0;
  endtask

  // Called right after the ARM edge; ends right after the verdict state is entered.
  task automatic play_round(input logic [6:0] g);
    tick(1);
    cnt_over = 1'b1;
    tick(1);
    cnt_over = 1'b0;
    guess   = g;
    start_p = 1'b1;
    tick(1);
    start_p = 1'b0;
    tick(1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; start_p = 1'b0; restart_p = 1'b0;
    cnt_over = 1'b0; beep_over = 1'b0; guess = 7'h00; rand_num = 7'h55;
    tick(3);
    chk("rst_pulses", 16'({rand_st, cnt_start, beep_start}), 16'h0000);
    chk("rst_codes", 16'({cnt_secs, dz_sel, beep_mode, disp_code, level}), 16'h0000);
    chk("rst_led", led, 16'h0000);

    rst = 1'b0; en = 1'b1;
    tick(1);
    chk("greet_dz", 16'(dz_sel), 16'd1);
    chk("greet_level", 16'(level), 16'd0);
    tick(1);

    // Level 1, target 0x55 -> 5-bit value 0x15
    pulse_restart();
    chk("arm1_pulses", 16'({rand_st, cnt_start}), 16'h0003);
    chk("arm1_secs", 16'(cnt_secs), 16'd3);
    chk("arm1_led", led, 16'h3C00);
    tick(1);
    chk("play_pulses", 16'({rand_st, cnt_start}), 16'h0000);
    chk("play_disp", 16'({dz_sel, disp_code}), 16'h0011);
    start_p = 1'b1;
    tick(1);
    start_p = 1'b0;
    tick(2);
    chk("play_ignores_start", 16'({dz_sel, disp_code, beep_start}), 16'h0022);
    cnt_over = 1'b1;
    tick(1);
    cnt_over = 1'b0;
    pulse_beep_over();
    tick(1);
    chk("stray_beep_over", 16'({dz_sel, disp_code, beep_start}), 16'h0022);
    guess = 7'h75;
    start_p = 1'b1;
    tick(1);
    start_p = 1'b0;
    chk("judge_led_mask", 16'(led[6:0]), 16'h0015);
    tick(1);
    chk("hit1", 16'({beep_start, beep_mode, dz_sel, disp_code}), 16'h011A);
    tick(1);
    chk("hit1_beep_width", 16'(beep_start), 16'd0);

    // Level 2, target 0x6A -> 6-bit value 0x2A
    rand_num = 7'h6A;
    pulse_beep_over();
    chk("arm2", 16'({rand_st, cnt_start, cnt_secs, level}), 16'h006A);
    chk("arm2_led", 16'(led[15:10]), 16'h001F);
    play_round(7'h2A);
    chk("hit2", 16'({beep_start, beep_mode, disp_code}), 16'h0022);

    // Level 3, target 0x3C (all 7 bits)
    rand_num = 7'h3C;
    pulse_beep_over();
    chk("arm3", 16'({rand_st, cnt_start, cnt_secs, level}), 16'h0067);
    play_round(7'h3C);
    chk("hit3", 16'({beep_start, beep_mode, disp_code}), 16'h0022);
    pulse_beep_over();
    chk("win", 16'({beep_mode, disp_code}), 16'h0014);
    chk("win_led_level", 16'(led[15:13]), 16'd7);
    tick(3);
    chk("win_holds", 16'({beep_mode, disp_code}), 16'h0014);

    // Three misses at level 1, target 0x0B
    rand_num = 7'h0B;
    pulse_restart();
    chk("restart_from_win", 16'({rand_st, cnt_start, cnt_secs, level}), 16'h006D);
    play_round(7'h0C);
    chk("miss1", 16'({beep_start, beep_mode, dz_sel, disp_code}), 16'h0163);
    chk("miss1_tries", 16'(led[12:10]), 16'd3);
    rand_num = 7'h7F;
    pulse_beep_over();
    chk("retry1_arm", 16'({rand_st, cnt_start, cnt_secs, level}), 16'h002D);
    play_round(7'h0C);
    chk("miss2_tries", 16'(led[12:10]), 16'd1);
    pulse_beep_over();
    chk("retry2_arm", 16'({rand_st, cnt_start, cnt_secs, level}), 16'h002D);
    play_round(7'h0C);
    chk("fail", 16'({beep_mode, disp_code}), 16'h001D);
    chk("fail_tries", 16'(led[12:10]), 16'd0);
    tick(2);
    chk("fail_holds", 16'({beep_mode, disp_code}), 16'h001D);

    // A retry keeps the old target even though rand_num has moved on
    rand_num = 7'h12;
    pulse_restart();
    play_round(7'h13);
    chk("miss_before_retry", 16'(disp_code), 16'd3);
    rand_num = 7'h00;
    pulse_beep_over();
    chk("retry_no_rand", 16'(rand_st), 16'd0);
    play_round(7'h12);
    chk("retry_keeps_target", 16'(disp_code), 16'd2);

    // start_p together with restart_p in GUESS: restart wins
    pulse_beep_over();
    tick(1);
    cnt_over = 1'b1;
    tick(1);
    cnt_over = 1'b0;
    start_p = 1'b1; restart_p = 1'b1;
    tick(1);
    start_p = 1'b0; restart_p = 1'b0;
    chk("start_restart_guess", 16'({rand_st, cnt_start, cnt_secs, level}), 16'h006D);
    tick(1);
    chk("after_restart_play", 16'({dz_sel, disp_code, beep_start}), 16'h0022);

    // Disable mid-PLAY
    en = 1'b0;
    tick(1);
    chk("off_outputs", 16'({rand_st, cnt_start, beep_start, dz_sel, disp_code, level}), 16'h0000);
    chk("off_led", led, 16'h0000);
    en = 1'b1;
    tick(1);
    chk("reenable_greet", 16'(dz_sel), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
